// File: rtl/ycbcr444_rgb888.sv
`default_nettype none
// ============================================================================
// Module      : ycbcr444_rgb888
// Description : 3-stage YCbCr 4:4:4 (8-bit) to RGB888 converter with matched
//               vsync/href/clken delay. Define YCBCR_LIMITED_RANGE_EN for
//               BT.601 studio-range input; full-range input otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module ycbcr444_rgb888 #(
    parameter int OUT_ZERO_BLANK = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Y,
    input  logic [7:0] per_img_Cb,
    input  logic [7:0] per_img_Cr,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_red,
    output logic [7:0] post_img_green,
    output logic [7:0] post_img_blue
);

    localparam logic signed [19:0] c_ROUND = 20'sd128;

`ifdef YCBCR_LIMITED_RANGE_EN
    localparam logic signed [19:0] c_K_Y   = 20'sd298;
    localparam logic signed [19:0] c_K_RCR = 20'sd409;
    localparam logic signed [19:0] c_K_GCB = 20'sd100;
    localparam logic signed [19:0] c_K_GCR = 20'sd208;
    localparam logic signed [19:0] c_K_BCB = 20'sd516;
`else
    localparam logic signed [19:0] c_K_RCR = 20'sd359;
    localparam logic signed [19:0] c_K_GCB = 20'sd88;
    localparam logic signed [19:0] c_K_GCR = 20'sd183;
    localparam logic signed [19:0] c_K_BCB = 20'sd454;
`endif

    // Negative sums go to 0; anything at or above 256 after the shift goes to 255.
    function automatic logic [7:0] clamp_u8(input logic signed [19:0] s);
        logic [7:0] v;
        if (s[19])
            v = 8'h00;
        else if (|s[18:16])
            v = 8'hFF;
        else
            v = s[15:8];
        return v;
    endfunction

    // Stage 1 operands
    logic signed [8:0]  w_cb_s;
    logic signed [8:0]  w_cr_s;
    logic signed [19:0] w_cb_x;
    logic signed [19:0] w_cr_x;
    logic signed [19:0] w_y_term;

    assign w_cb_s = $signed({1'b0, per_img_Cb}) - 9'sd128;
    assign w_cr_s = $signed({1'b0, per_img_Cr}) - 9'sd128;
    assign w_cb_x = {{11{w_cb_s[8]}}, w_cb_s};
    assign w_cr_x = {{11{w_cr_s[8]}}, w_cr_s};

`ifdef YCBCR_LIMITED_RANGE_EN
    logic signed [8:0]  w_y_s;
    logic signed [19:0] w_y_x;
    assign w_y_s    = $signed({1'b0, per_img_Y}) - 9'sd16;
    assign w_y_x    = {{11{w_y_s[8]}}, w_y_s};
    assign w_y_term = w_y_x * c_K_Y;
`else
    assign w_y_term = $signed({4'b0000, per_img_Y, 8'h00});
`endif

    logic signed [19:0] r_y_term;
    logic signed [19:0] r_p_rcr;
    logic signed [19:0] r_p_gcb;
    logic signed [19:0] r_p_gcr;
    logic signed [19:0] r_p_bcb;
    logic signed [19:0] r_sum_r;
    logic signed [19:0] r_sum_g;
    logic signed [19:0] r_sum_b;
    logic [7:0]         r_red;
    logic [7:0]         r_green;
    logic [7:0]         r_blue;
    logic [2:0]         r_vsync_d;
    logic [2:0]         r_href_d;
    logic [2:0]         r_clken_d;

    // The datapath runs every cycle; clken only travels alongside as a tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_term  <= '0;
            r_p_rcr   <= '0;
            r_p_gcb   <= '0;
            r_p_gcr   <= '0;
            r_p_bcb   <= '0;
            r_sum_r   <= '0;
            r_sum_g   <= '0;
            r_sum_b   <= '0;
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
            r_vsync_d <= '0;
            r_href_d  <= '0;
            r_clken_d <= '0;
        end else begin
            r_y_term  <= w_y_term;
            r_p_rcr   <= w_cr_x * c_K_RCR;
            r_p_gcb   <= w_cb_x * c_K_GCB;
            r_p_gcr   <= w_cr_x * c_K_GCR;
            r_p_bcb   <= w_cb_x * c_K_BCB;

            r_sum_r   <= r_y_term + r_p_rcr + c_ROUND;
            r_sum_g   <= r_y_term - r_p_gcb - r_p_gcr + c_ROUND;
            r_sum_b   <= r_y_term + r_p_bcb + c_ROUND;

            r_red     <= clamp_u8(r_sum_r);
            r_green   <= clamp_u8(r_sum_g);
            r_blue    <= clamp_u8(r_sum_b);

            r_vsync_d <= {r_vsync_d[1:0], per_frame_vsync};
            r_href_d  <= {r_href_d[1:0],  per_frame_href};
            r_clken_d <= {r_clken_d[1:0], per_frame_clken};
        end
    end

    assign post_frame_vsync = r_vsync_d[2];
    assign post_frame_href  = r_href_d[2];
    assign post_frame_clken = r_clken_d[2];

    generate
        if (OUT_ZERO_BLANK != 0) begin : g_blank
            assign post_img_red   = r_href_d[2] ? r_red   : 8'h00;
            assign post_img_green = r_href_d[2] ? r_green : 8'h00;
            assign post_img_blue  = r_href_d[2] ? r_blue  : 8'h00;
        end else begin : g_pass
            assign post_img_red   = r_red;
            assign post_img_green = r_green;
            assign post_img_blue  = r_blue;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ycbcr444_rgb888.sv
`default_nettype none
// ============================================================================
// Module      : tb_ycbcr444_rgb888
// Description : Directed self-checking bench for ycbcr444_rgb888 (honours
//               YCBCR_LIMITED_RANGE_EN the same way as the design).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ycbcr444_rgb888;

    logic       clk;
    logic       rst_n;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic [7:0] per_img_Y;
    logic [7:0] per_img_Cb;
    logic [7:0] per_img_Cr;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [7:0] post_img_red;
    logic [7:0] post_img_green;
    logic [7:0] post_img_blue;

    int n_checks = 0;
    int n_errors = 0;

    localparam int c_N = 40;

    logic [7:0] a_y  [c_N];
    logic [7:0] a_cb [c_N];
    logic [7:0] a_cr [c_N];
    logic       a_v  [c_N];
    logic       a_h  [c_N];
    logic       a_c  [c_N];

    ycbcr444_rgb888 u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Y        (per_img_Y),
        .per_img_Cb       (per_img_Cb),
        .per_img_Cr       (per_img_Cr),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_red     (post_img_red),
        .post_img_green   (post_img_green),
        .post_img_blue    (post_img_blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sat(input int v);
        logic [31:0] u;
        u = v;
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return u[7:0];
    endfunction

    function automatic logic [23:0] model(input int y, input int cb, input int cr);
        int r, g, b;
`ifdef YCBCR_LIMITED_RANGE_EN
        r = (298 * (y - 16) + 409 * (cr - 128) + 128) >>> 8;
        g = (298 * (y - 16) - 100 * (cb - 128) - 208 * (cr - 128) + 128) >>> 8;
        b = (298 * (y - 16) + 516 * (cb - 128) + 128) >>> 8;
`else
        r = (256 * y + 359 * (cr - 128) + 128) >>> 8;
        g = (256 * y - 88 * (cb - 128) - 183 * (cr - 128) + 128) >>> 8;
        b = (256 * y + 454 * (cb - 128) + 128) >>> 8;
`endif
        return {sat(r), sat(g), sat(b)};
    endfunction

    task automatic drive(input logic v, input logic h, input logic c,
                         input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        per_frame_vsync = v;
        per_frame_href  = h;
        per_frame_clken = c;
        per_img_Y       = y;
        per_img_Cb      = cb;
        per_img_Cr      = cr;
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] rgb();
        return {post_img_red, post_img_green, post_img_blue};
    endfunction

    function automatic logic [2:0] sync();
        return {post_frame_vsync, post_frame_href, post_frame_clken};
    endfunction

    task automatic pix_check(input string tag, input logic [7:0] y, input logic [7:0] cb,
                             input logic [7:0] cr, input logic [23:0] exp);
        drive(1'b0, 1'b1, 1'b1, y, cb, cr);
        repeat (3) step();
        check(tag, {8'h00, rgb()}, {8'h00, exp});
    endtask

    logic [23:0] exp_mid;
    logic [23:0] exp_rst;
    logic [23:0] exp_rgb;
    int          idx;

    initial begin
`ifdef YCBCR_LIMITED_RANGE_EN
        exp_mid = 24'h828282;
        exp_rst = 24'hFF0000;
`else
        exp_mid = 24'h808080;
        exp_rst = 24'hFE0000;
`endif
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        #2;
        check("reset_rgb", {8'h00, rgb()}, 32'h0);
        check("reset_sync", {29'h0, sync()}, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single pixel latency: sampled at edge 1, visible after edge 3 only.
        repeat (2) step();
        drive(1'b1, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        check("lat_e1_sync", {29'h0, sync()}, 32'h0);
        step();
        check("lat_e2_sync", {29'h0, sync()}, 32'h0);
        step();
        check("lat_e3_sync", {29'h0, sync()}, 32'h7);
        check("lat_e3_rgb", {8'h00, rgb()}, {8'h00, exp_mid});
        step();
        check("lat_e4_sync", {29'h0, sync()}, 32'h0);
        check("lat_e4_rgb", {8'h00, rgb()}, 32'h0);

`ifdef YCBCR_LIMITED_RANGE_EN
        pix_check("lim_black", 8'd16, 8'd128, 8'd128, 24'h000000);
        pix_check("lim_white", 8'd235, 8'd128, 8'd128, 24'hFFFFFF);
        pix_check("lim_under", 8'd0, 8'd128, 8'd128, 24'h000000);
`else
        pix_check("grey", 8'd128, 8'd128, 8'd128, 24'h808080);
        pix_check("sat_hi", 8'd255, 8'd128, 8'd255, 24'hFFA4FF);
        pix_check("sat_lo", 8'd0, 8'd0, 8'd0, 24'h008800);
        pix_check("red", 8'd76, 8'd85, 8'd255, 24'hFE0000);
`endif

        // Continuous ramp with a 5-cycle href gap and varying clken/vsync.
        for (int j = 0; j < c_N; j++) begin
            a_y[j]  = 8'((j * 7 + 3) % 256);
            a_cb[j] = 8'((255 - j * 6) % 256);
            a_cr[j] = 8'((j * 37) % 256);
            a_v[j]  = (j < 2);
            a_h[j]  = !(j >= 15 && j < 20);
            a_c[j]  = (j % 3 != 0);
        end
        for (int j = 0; j < c_N + 2; j++) begin
            if (j < c_N)
                drive(a_v[j], a_h[j], a_c[j], a_y[j], a_cb[j], a_cr[j]);
            else
                drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
            step();
            if (j >= 2) begin
                idx = j - 2;
                exp_rgb = a_h[idx] ? model(int'(a_y[idx]), int'(a_cb[idx]), int'(a_cr[idx]))
                                   : 24'h0;
                check($sformatf("ramp_sync[%0d]", idx), {29'h0, sync()},
                      {29'h0, a_v[idx], a_h[idx], a_c[idx]});
                check($sformatf("ramp_rgb[%0d]", idx), {8'h00, rgb()}, {8'h00, exp_rgb});
            end
        end

        // Asynchronous reset mid-line, then recovery latency.
        drive(1'b1, 1'b1, 1'b1, 8'd76, 8'd85, 8'd255);
        repeat (4) step();
        check("pre_rst_rgb", {8'h00, rgb()}, {8'h00, exp_rst});
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb", {8'h00, rgb()}, 32'h0);
        check("async_rst_sync", {29'h0, sync()}, 32'h0);
        repeat (2) step();
        check("held_rst_rgb", {8'h00, rgb()}, 32'h0);
        #2 rst_n = 1'b1;
        step();
        check("rel_e1_sync", {29'h0, sync()}, 32'h0);
        check("rel_e1_rgb", {8'h00, rgb()}, 32'h0);
        step();
        check("rel_e2_sync", {29'h0, sync()}, 32'h0);
        step();
        check("rel_e3_sync", {29'h0, sync()}, 32'h7);
        check("rel_e3_rgb", {8'h00, rgb()}, {8'h00, exp_rst});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ycbcr444_rgb888.md
Name: ycbcr444_rgb888

Overview:
- Inverse colour-space converter: 8-bit full-range YCbCr 4:4:4 in, RGB888 out.
- Sits on the display/write-back side of the video pipeline, after YCbCr-domain processing.
- Fixed 3-stage arithmetic pipeline; frame sync signals are delayed to match.
- Uses the same per_frame/post_frame vsync/href/clken interface as the forward RGB-to-YCbCr converter.

Parameters:
- OUT_ZERO_BLANK, default 1: when 1, post_img_* are forced to 0 while post_frame_href=0; when 0, the pipeline data passes through unmasked.

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  reset, asynchronous, active-low
- per_frame_vsync  input  1  input vsync
- per_frame_href  input  1  input line valid
- per_frame_clken  input  1  input pixel enable
- per_img_Y  input  8  luma
- per_img_Cb  input  8  blue-difference chroma, offset 128
- per_img_Cr  input  8  red-difference chroma, offset 128
- post_frame_vsync  output  1  vsync delayed 3 clk
- post_frame_href  output  1  href delayed 3 clk
- post_frame_clken  output  1  clken delayed 3 clk
- post_img_red  output  8  red
- post_img_green  output  8  green
- post_img_blue  output  8  blue

Behaviour:
- Equations (default, full range):
  - R = (256*Y + 359*(Cr-128) + 128) >>> 8
  - G = (256*Y - 88*(Cb-128) - 183*(Cr-128) + 128) >>> 8
  - B = (256*Y + 454*(Cb-128) + 128) >>> 8
- Stage 1 (registered):
  - cb_s = Cb-128 and cr_s = Cr-128, 9-bit signed.
  - y_s = {Y,8'h00}.
  - Products 359*cr_s, 88*cb_s, 183*cr_s, 454*cb_s, each 20-bit signed.
- Stage 2 (registered): the three sums including the +128 rounding term, each 20-bit signed. No overflow is possible in 20 bits.
- Stage 3 (registered): arithmetic shift right by 8, then clamp.
  - Sign bit set -> 0.
  - Result >255 -> 255.
  - Otherwise bits [15:8] of the sum.
- Latency: exactly 3 clk from input to output.
  - The pipeline runs every clk and is not qualified by clken.
  - Data samples on cycles where clken=0 propagate but are don't-care downstream.
- Sync: vsync, href and clken each pass through a 3-deep shift register. post_* equals per_* from 3 cycles earlier.
- Output gating (OUT_ZERO_BLANK=1): post_img_* = post_frame_href ? stage-3 value : 0.
- Reset:
  - Asserting rst_n low asynchronously clears all pipeline and sync registers, so every output is 0 immediately.
  - Reset mid-line discards in-flight pixels.
  - After release, the first output reflecting new input appears 3 clk after that input is sampled; outputs stay 0 until then.
- Back-to-back pixels are accepted every cycle with no stalls and no backpressure.
- Boundary: inputs 0 and 255 on any channel are legal. Out-of-gamut results saturate and never wrap.

Optional Feature:
- Macro YCBCR_LIMITED_RANGE_EN.
- When defined, the input is BT.601 studio range and the equations become:
  - R = (298*(Y-16) + 409*(Cr-128) + 128) >>> 8
  - G = (298*(Y-16) - 100*(Cb-128) - 208*(Cr-128) + 128) >>> 8
  - B = (298*(Y-16) + 516*(Cb-128) + 128) >>> 8
  - Y-16 is 9-bit signed, so Y<16 yields a negative term.
  - Latency, widths (20-bit signed), clamping and sync handling are unchanged.
- When not defined, the full-range equations above apply.

Test Plan:
- Full range, Y=128, Cb=128, Cr=128 with href=1 -> RGB=(128,128,128) exactly 3 clk later.
- Y=255, Cb=128, Cr=255 -> (255,164,255): R saturates from 433, B from 255.5 truncates to 255.
- Y=0, Cb=0, Cr=0 -> (0,136,0): R and B clamp negative results to 0.
- Y=76, Cb=85, Cr=255 -> (254,0,0). Stream a continuous 1-per-clk ramp and check every output against a golden model, with 3-clk alignment of vsync/href/clken.
- Drop href for 5 cycles mid-line -> post_frame_href low for those 5 cycles (offset by 3 clk) and post_img_*=0. Assert rst_n low mid-line -> all outputs 0 asynchronously. After release, the first valid pixel appears 3 clk after input.
- With YCBCR_LIMITED_RANGE_EN: Y=16, Cb=Cr=128 -> (0,0,0); Y=235, Cb=Cr=128 -> (255,255,255); Y=0, Cb=Cr=128 -> (0,0,0) via clamp.
